mem_wb_writeback: RTL and testbench



---
 rtl/mem_wb_writeback.sv | 76 +++++++
 tb/tb_mem_wb_writeback.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with write-back mux, register-file write port,
// write-through read bypass and a retired-instruction counter.
module mem_wb_writeback #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic                      in_reg_write,
    input  logic                      in_mem_to_reg,
    input  logic                      in_link,
    input  logic [REG_ADDR_WIDTH-1:0] in_write_reg,
    input  logic [DATA_WIDTH-1:0]     in_alu_result,
    input  logic [DATA_WIDTH-1:0]     in_mem_data,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus1,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_reg_2,
    input  logic [DATA_WIDTH-1:0]     rf_read_data_1,
    input  logic [DATA_WIDTH-1:0]     rf_read_data_2,
    output logic                      reg_write,
    output logic [REG_ADDR_WIDTH-1:0] write_reg,
    output logic [DATA_WIDTH-1:0]     write_data,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    output logic                      wb_valid,
    output logic [15:0]               retired_count
);

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  capture;

    always_comb begin
        if (in_link)
            sel_data = in_pc_plus1;
        else if (in_mem_to_reg)
            sel_data = in_mem_data;
        else
            sel_data = in_alu_result;
    end

    assign capture = !flush && !stall;

    // R0 is hardwired to zero, so a write to it is dropped before capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (!stall) begin
            wb_valid   <= in_valid;
            reg_write  <= in_valid && in_reg_write && (in_write_reg != '0);
            write_reg  <= in_write_reg;
            write_data <= sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            retired_count <= '0;
        else if (capture && in_valid)
            retired_count <= retired_count + 16'd1;
    end

    assign read_data_1 = (reg_write && (write_reg == read_reg_1)) ? write_data : rf_read_data_1;
    assign read_data_2 = (reg_write && (write_reg == read_reg_2)) ? write_data : rf_read_data_2;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: directed scenarios plus
// randomized traffic compared against a pending-write reference model.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_reg_write, in_mem_to_reg, in_link;
    logic [2:0]  in_write_reg, read_reg_1, read_reg_2;
    logic [15:0] in_alu_result, in_mem_data, in_pc_plus1;
    logic [15:0] rf_read_data_1, rf_read_data_2;
    logic        reg_write, wb_valid;
    logic [2:0]  write_reg;
    logic [15:0] write_data, read_data_1, read_data_2, retired_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the write the stage is currently presenting, and a tally.
    logic        m_valid, m_write;
    logic [2:0]  m_reg;
    logic [15:0] m_value;
    logic [15:0] m_retired;

    always #5 clk = ~clk;

    mem_wb_writeback #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_reg_write(in_reg_write),
        .in_mem_to_reg(in_mem_to_reg), .in_link(in_link),
        .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_pc_plus1(in_pc_plus1),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    function automatic logic [15:0] wb_value();
        if (in_link) return in_pc_plus1;
        if (in_mem_to_reg) return in_mem_data;
        return in_alu_result;
    endfunction

    // One rising edge; the model follows the same edge, then sample #1 later.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_write = 0; m_reg = 0; m_value = 0; m_retired = 0;
        end else if (flush) begin
            m_valid = 0; m_write = 0; m_reg = 0; m_value = 0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_write = in_valid && in_reg_write && (in_write_reg != 3'd0);
            m_reg   = in_write_reg;
            m_value = wb_value();
            if (in_valid) m_retired = m_retired + 16'd1;
        end
        #1;
    endtask

    task automatic rand_inputs();
        in_valid       = 1'($urandom);
        in_reg_write   = 1'($urandom);
        in_mem_to_reg  = 1'($urandom);
        in_link        = 1'($urandom_range(0, 3) == 0);
        in_write_reg   = 3'($urandom);
        in_alu_result  = 16'($urandom);
        in_mem_data    = 16'($urandom);
        in_pc_plus1    = 16'($urandom);
        read_reg_1     = 3'($urandom);
        read_reg_2     = 3'($urandom);
        rf_read_data_1 = 16'($urandom);
        rf_read_data_2 = 16'($urandom);
    endtask

    task automatic set_write(input logic [2:0] r, input logic m2r, input logic lnk,
                             input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pc);
        in_valid = 1; in_reg_write = 1; in_write_reg = r;
        in_mem_to_reg = m2r; in_link = lnk;
        in_alu_result = alu; in_mem_data = mem; in_pc_plus1 = pc;
    endtask

    task automatic do_reset();
        rst = 1; stall = 0; flush = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; stall = 1'($urandom); flush = 1'($urandom);
        rand_inputs(); tick();
        rand_inputs(); tick();
        vectors++;
        if (reg_write !== 1'b0 || write_reg !== 3'd0 || write_data !== 16'h0 ||
            wb_valid !== 1'b0 || retired_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rw=%b wr=%0d wd=%h v=%b cnt=%h, want all 0",
                     reg_write, write_reg, write_data, wb_valid, retired_count);
        end
        vectors++;
        if (read_data_1 !== rf_read_data_1 || read_data_2 !== rf_read_data_2) begin
            miscompares++;
            $display("FAIL reset_passthru: got %h/%h, want %h/%h",
                     read_data_1, read_data_2, rf_read_data_1, rf_read_data_2);
        end
        rst = 0; stall = 0; flush = 0;
    endtask

    task automatic test_basic_mux();
        set_write(3'd7, 0, 0, 16'h1234, 16'h9999, 16'h7777);
        tick();
        vectors++;
        if (reg_write !== 1'b1 || write_reg !== 3'd7 || write_data !== 16'h1234) begin
            miscompares++;
            $display("FAIL mux_alu: got rw=%b wr=%0d wd=%h, want 1/7/1234", reg_write, write_reg, write_data);
        end
        set_write(3'd7, 1, 0, 16'h1234, 16'hBEEF, 16'h7777);
        tick();
        vectors++;
        if (reg_write !== 1'b1 || write_reg !== 3'd7 || write_data !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL mux_mem: got rw=%b wr=%0d wd=%h, want 1/7/beef", reg_write, write_reg, write_data);
        end
        set_write(3'd7, 1, 1, 16'h1234, 16'hBEEF, 16'h0042);
        tick();
        vectors++;
        if (reg_write !== 1'b1 || write_reg !== 3'd7 || write_data !== 16'h0042) begin
            miscompares++;
            $display("FAIL mux_link: got rw=%b wr=%0d wd=%h, want 1/7/0042", reg_write, write_reg, write_data);
        end
    endtask

    task automatic test_bypass();
        set_write(3'd3, 0, 0, 16'h00AA, 16'h1111, 16'h2222);
        tick();
        read_reg_1 = 3'd3; rf_read_data_1 = 16'h0000;
        read_reg_2 = 3'd4; rf_read_data_2 = 16'h5555;
        #1;
        vectors++;
        if (read_data_1 !== 16'h00AA) begin
            miscompares++;
            $display("FAIL bypass_hit: got %h, want 00aa", read_data_1);
        end
        vectors++;
        if (read_data_2 !== 16'h5555) begin
            miscompares++;
            $display("FAIL bypass_miss: got %h, want 5555", read_data_2);
        end
        read_reg_2 = 3'd3; rf_read_data_2 = 16'h0101;
        #1;
        vectors++;
        if (read_data_1 !== 16'h00AA || read_data_2 !== 16'h00AA) begin
            miscompares++;
            $display("FAIL bypass_both: got %h/%h, want 00aa/00aa", read_data_1, read_data_2);
        end
    endtask

    task automatic test_r0();
        set_write(3'd0, 0, 0, 16'hFFFF, 16'h1111, 16'h2222);
        tick();
        read_reg_1 = 3'd0; rf_read_data_1 = 16'h0000;
        #1;
        vectors++;
        if (reg_write !== 1'b0 || read_data_1 !== 16'h0000 || wb_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_suppress: got rw=%b rd1=%h v=%b, want 0/0000/1", reg_write, read_data_1, wb_valid);
        end
    endtask

    task automatic test_stall_flush();
        logic [15:0] cnt0;
        set_write(3'd5, 0, 0, 16'h5A5A, 16'h0, 16'h0);
        tick();
        cnt0 = retired_count;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            in_valid = 1;
            tick();
            vectors++;
            if (reg_write !== 1'b1 || write_reg !== 3'd5 || write_data !== 16'h5A5A || retired_count !== cnt0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got rw=%b wr=%0d wd=%h cnt=%h, want 1/5/5a5a cnt=%h",
                         i, reg_write, write_reg, write_data, retired_count, cnt0);
            end
        end
        flush = 1;
        tick();
        vectors++;
        if (reg_write !== 1'b0 || wb_valid !== 1'b0 || write_data !== 16'h0 || retired_count !== cnt0) begin
            miscompares++;
            $display("FAIL flush_stall: got rw=%b v=%b wd=%h cnt=%h, want 0/0/0000 cnt=%h",
                     reg_write, wb_valid, write_data, retired_count, cnt0);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_reset_mid();
        set_write(3'd6, 0, 0, 16'hC0DE, 16'h0, 16'h0);
        tick();
        rst = 1;
        rand_inputs();
        tick();
        rst = 0;
        vectors++;
        if (reg_write !== 1'b0 || wb_valid !== 1'b0 || retired_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got rw=%b v=%b cnt=%h, want 0/0/0000", reg_write, wb_valid, retired_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            rf_read_data_1 = 16'($urandom);
            read_reg_1 = ($urandom_range(0, 1) == 0) ? m_reg : 3'($urandom);
            read_reg_2 = 3'($urandom);
            #1;
            vectors++;
            if (wb_valid !== m_valid || reg_write !== m_write || write_reg !== m_reg ||
                write_data !== m_value || retired_count !== m_retired) begin
                miscompares++;
                $display("FAIL random_stage[%0d]: got v=%b rw=%b wr=%0d wd=%h cnt=%h, want v=%b rw=%b wr=%0d wd=%h cnt=%h",
                         i, wb_valid, reg_write, write_reg, write_data, retired_count,
                         m_valid, m_write, m_reg, m_value, m_retired);
            end
            vectors++;
            if (read_data_1 !== ((m_write && m_reg == read_reg_1) ? m_value : rf_read_data_1) ||
                read_data_2 !== ((m_write && m_reg == read_reg_2) ? m_value : rf_read_data_2)) begin
                miscompares++;
                $display("FAIL random_bypass[%0d]: got %h/%h for regs %0d/%0d", i,
                         read_data_1, read_data_2, read_reg_1, read_reg_2);
            end
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_wrap();
        int captured = 0;
        do_reset();
        while (captured < 65536) begin
            rand_inputs();
            in_valid = ($urandom_range(0, 15) != 0);
            if (in_valid) captured++;
            tick();
            if (captured == 40000 && in_valid) begin
                vectors++;
                if (retired_count !== 16'd40000) begin
                    miscompares++;
                    $display("FAIL wrap_mid: got %0d, want 40000", retired_count);
                end
            end
        end
        vectors++;
        if (retired_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_zero: got %h, want 0000", retired_count);
        end
        in_valid = 0;
        tick();
        vectors++;
        if (retired_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap_invalid: got %h, want 0000", retired_count);
        end
    endtask

    initial begin
        rst = 1; stall = 0; flush = 0;
        m_valid = 0; m_write = 0; m_reg = 0; m_value = 0; m_retired = 0;
        rand_inputs();
        test_reset();
        test_basic_mux();
        test_bypass();
        test_r0();
        test_stall_flush();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
